// File: rtl/matmul_addr_seq_pkg.sv
// Shared definitions for the matmul read-address sequencer: FSM states,
// chunks-per-dot-product helper and the input RAM read latency.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int RAM_RD_LATENCY = 1;

  function automatic int calc_nk(input int inner_dim, input int chunk_size);
    calc_nk = inner_dim / chunk_size;
  endfunction

endpackage

// File: rtl/matmul_addr_seq_if.sv
// Handshake/sideband bundle between the sequencer (master) and the
// controller/MAC side (slave).
interface matmul_addr_seq_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             stall;
  logic [WIDTH-1:0] counter_A;
  logic [WIDTH-1:0] counter_B;
  logic             data_valid;
  logic             k_first;
  logic             k_last;
  logic [WIDTH-1:0] out_row;
  logic [WIDTH-1:0] out_col;
  logic             busy;
  logic             done;

  modport master (
    input  start, stall,
    output counter_A, counter_B, data_valid, k_first, k_last,
           out_row, out_col, busy, done
  );

  modport slave (
    output start, stall,
    input  counter_A, counter_B, data_valid, k_first, k_last,
           out_row, out_col, busy, done
  );

endinterface

// File: rtl/matmul_addr_seq_idx_counter.sv
// Nested i/j/k loop counter (k innermost) with enable, synchronous clear,
// k-wrap flag and a flag marking the final (OUTER-1, OUTER-1, NK-1) triple.
module matmul_idx_counter #(
  parameter int WIDTH = 16,
  parameter int OUTER = 6,
  parameter int NK    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             k_wrap,
  output logic             last
);

  localparam logic [WIDTH-1:0] K_MAX = WIDTH'(NK - 1);
  localparam logic [WIDTH-1:0] O_MAX = WIDTH'(OUTER - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic j_wrap_s;

  assign k_wrap   = (k == K_MAX);
  assign j_wrap_s = k_wrap && (j == O_MAX);
  assign last     = j_wrap_s && (i == O_MAX);

  // Index registers: k steps every enable, j on k wrap, i on j wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (clr) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (en) begin
      if (k_wrap) begin
        k <= '0;
        if (j_wrap_s) begin
          j <= '0;
          i <= last ? '0 : i + ONE;
        end else begin
          j <= j + ONE;
        end
      end else begin
        k <= k + ONE;
      end
    end
  end

endmodule

// File: rtl/matmul_addr_seq.sv
// Read-address sequencer feeding the dual-port input RAM; sideband is delayed
// to align with RAM read data. Optional stall counter: MATMUL_ADDR_SEQ_STALL_CNT_EN.
module matmul_addr_seq
  import matmul_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int CHUNK_SIZE      = 4,
  parameter int INNER_DIMENSION = 4,
  parameter int OUTER_DIMENSION = 6
) (
  input  logic              clk,
  input  logic              rst,
  matmul_addr_seq_if.master bus
`ifdef MATMUL_ADDR_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int NK        = calc_nk(INNER_DIMENSION, CHUNK_SIZE);
  localparam int SB_STAGES = 1 + RAM_RD_LATENCY;
  localparam logic [WIDTH-1:0] NK_W = WIDTH'(NK);

  state_t               state_r, state_s;
  logic                 issue_s, start_ok_s, k_wrap_s, last_s;
  logic [WIDTH-1:0]     i_s, j_s, k_s;
  logic [WIDTH-1:0]     counter_a_r, counter_b_r;
  logic [SB_STAGES-1:0] sb_valid_r, sb_first_r, sb_last_r;
  logic [WIDTH-1:0]     sb_row_r [SB_STAGES];
  logic [WIDTH-1:0]     sb_col_r [SB_STAGES];
  logic                 busy_r, done_r;

  assign start_ok_s = (state_r == IDLE) && bus.start;
  assign issue_s    = (state_r == RUN) && !bus.stall;

  matmul_idx_counter #(
    .WIDTH (WIDTH),
    .OUTER (OUTER_DIMENSION),
    .NK    (NK)
  ) u_idx (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_ok_s),
    .en     (issue_s),
    .i      (i_s),
    .j      (j_s),
    .k      (k_s),
    .k_wrap (k_wrap_s),
    .last   (last_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next state; DRAIN holds until the sideband pipe has emptied.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start_ok_s) state_s = RUN; else state_s = IDLE;
      RUN:     if (issue_s && last_s) state_s = DRAIN; else state_s = RUN;
      DRAIN:   if (sb_valid_r == '0) state_s = DONE; else state_s = DRAIN;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Registered status derived from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == RUN) || (state_s == DRAIN);
      done_r <= (state_s == DONE);
    end
  end

  // RAM addresses move only on issue, so a stall re-reads the same words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_a_r <= '0;
      counter_b_r <= '0;
    end else if (issue_s) begin
      counter_a_r <= i_s * NK_W + k_s;
      counter_b_r <= j_s * NK_W + k_s;
    end
  end

  // Sideband delay line: stage 0 tracks the address register, the last stage the RAM output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_valid_r <= '0;
      sb_first_r <= '0;
      sb_last_r  <= '0;
      for (int s = 0; s < SB_STAGES; s++) begin
        sb_row_r[s] <= '0;
        sb_col_r[s] <= '0;
      end
    end else begin
      sb_valid_r  <= {sb_valid_r[SB_STAGES-2:0], issue_s};
      sb_first_r  <= {sb_first_r[SB_STAGES-2:0], (k_s == '0)};
      sb_last_r   <= {sb_last_r[SB_STAGES-2:0], k_wrap_s};
      sb_row_r[0] <= i_s;
      sb_col_r[0] <= j_s;
      for (int s = 1; s < SB_STAGES; s++) begin
        sb_row_r[s] <= sb_row_r[s-1];
        sb_col_r[s] <= sb_col_r[s-1];
      end
    end
  end

  assign bus.counter_A  = counter_a_r;
  assign bus.counter_B  = counter_b_r;
  assign bus.data_valid = sb_valid_r[SB_STAGES-1];
  assign bus.k_first    = sb_first_r[SB_STAGES-1];
  assign bus.k_last     = sb_last_r[SB_STAGES-1];
  assign bus.out_row    = sb_row_r[SB_STAGES-1];
  assign bus.out_col    = sb_col_r[SB_STAGES-1];
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

`ifdef MATMUL_ADDR_SEQ_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of RUN cycles spent stalled; cleared by an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if (start_ok_s) begin
      stall_cnt_r <= 32'd0;
    end else if ((state_r == RUN) && bus.stall && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_matmul_addr_seq.sv
// Directed bench: default (NK=1) and INNER_DIMENSION=8 (NK=2) sequencers,
// cycle table for start/stall timing plus full-run pair scoreboards.
module tb_matmul_addr_seq;

  localparam int W = 16;

  typedef struct {
    int row; int col; int a; int b; bit first; bit last; int cyc;
  } pair_t;

  typedef struct {
    bit start; bit stall; bit busy; bit valid; int row; int col; int ca; int cb; bit done;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matmul_addr_seq_if #(.WIDTH(W)) b4 ();
  matmul_addr_seq_if #(.WIDTH(W)) b8 ();
`ifdef MATMUL_ADDR_SEQ_STALL_CNT_EN
  logic [31:0] sc4, sc8;
`endif

  matmul_addr_seq #(.WIDTH(W), .CHUNK_SIZE(4), .INNER_DIMENSION(4), .OUTER_DIMENSION(6)) u4 (
    .clk(clk), .rst(rst), .bus(b4)
`ifdef MATMUL_ADDR_SEQ_STALL_CNT_EN
    , .stall_cycles(sc4)
`endif
  );

  matmul_addr_seq #(.WIDTH(W), .CHUNK_SIZE(4), .INNER_DIMENSION(8), .OUTER_DIMENSION(6)) u8 (
    .clk(clk), .rst(rst), .bus(b8)
`ifdef MATMUL_ADDR_SEQ_STALL_CNT_EN
    , .stall_cycles(sc8)
`endif
  );

  int    n_checks, n_pass;
  int    cyc;
  pair_t q4[$], q8[$];
  int    done_cnt4, done_cnt8, done_cyc4, done_cyc8;
  int    pa4, pb4, pa8, pb8;
  pair_t exp4[36];
  pair_t exp8[72];
  vec_t  vt[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0d, required %0d", name, act, req);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Monitor: records each valid pair with the address presented one cycle earlier.
  initial begin
    cyc = 0; done_cnt4 = 0; done_cnt8 = 0; done_cyc4 = 0; done_cyc8 = 0;
    pa4 = 0; pb4 = 0; pa8 = 0; pb8 = 0;
    forever begin
      pair_t p;
      @(negedge clk);
      cyc++;
      if (b4.data_valid === 1'b1) begin
        p.row = int'(b4.out_row); p.col = int'(b4.out_col); p.a = pa4; p.b = pb4;
        p.first = b4.k_first; p.last = b4.k_last; p.cyc = cyc;
        q4.push_back(p);
      end
      if (b4.done === 1'b1) begin done_cnt4++; done_cyc4 = cyc; end
      if (b8.data_valid === 1'b1) begin
        p.row = int'(b8.out_row); p.col = int'(b8.out_col); p.a = pa8; p.b = pb8;
        p.first = b8.k_first; p.last = b8.k_last; p.cyc = cyc;
        q8.push_back(p);
      end
      if (b8.done === 1'b1) begin done_cnt8++; done_cyc8 = cyc; end
      pa4 = int'(b4.counter_A); pb4 = int'(b4.counter_B);
      pa8 = int'(b8.counter_A); pb8 = int'(b8.counter_B);
    end
  end

  task automatic clear_mon(input int sel);
    if (sel == 0) begin q4.delete(); done_cnt4 = 0; end
    else begin q8.delete(); done_cnt8 = 0; end
  endtask

  task automatic wait_done(input int sel, input int budget, input string tag);
    int n = 0;
    while (((sel == 0) ? done_cnt4 : done_cnt8) == 0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, (((sel == 0) ? done_cnt4 : done_cnt8) > 0), 1);
    repeat (3) step();
  endtask

  task automatic compare_run(input int sel, input string tag);
    int    n_exp = (sel == 0) ? 36 : 72;
    int    n_got = (sel == 0) ? q4.size() : q8.size();
    pair_t g, e;
    check({tag, "_pair_count"}, n_got, n_exp);
    for (int n = 0; n < n_exp && n < n_got; n++) begin
      g = (sel == 0) ? q4[n] : q8[n];
      e = (sel == 0) ? exp4[n] : exp8[n];
      check($sformatf("%s_p%0d_row", tag, n), g.row, e.row);
      check($sformatf("%s_p%0d_col", tag, n), g.col, e.col);
      check($sformatf("%s_p%0d_addrA", tag, n), g.a, e.a);
      check($sformatf("%s_p%0d_addrB", tag, n), g.b, e.b);
      check($sformatf("%s_p%0d_kfirst", tag, n), g.first, e.first);
      check($sformatf("%s_p%0d_klast", tag, n), g.last, e.last);
    end
    check({tag, "_done_pulses"}, (sel == 0) ? done_cnt4 : done_cnt8, 1);
    if (n_got > 0) begin
      g = (sel == 0) ? q4[n_got-1] : q8[n_got-1];
      check({tag, "_done_after_last_valid"}, ((sel == 0) ? done_cyc4 : done_cyc8) - g.cyc, 2);
    end
  endtask

  initial begin
    int n, odd_gaps;
    n_checks = 0; n_pass = 0;
    rst = 1'b1;
    b4.start = 1'b0; b4.stall = 1'b0;
    b8.start = 1'b0; b8.stall = 1'b0;

    for (int p = 0; p < 36; p++)
      exp4[p] = '{row: p / 6, col: p % 6, a: p / 6, b: p % 6, first: 1'b1, last: 1'b1, cyc: 0};
    for (int p = 0; p < 72; p++)
      exp8[p] = '{row: p / 12, col: (p / 2) % 6, a: 2 * (p / 12) + p % 2, b: 2 * ((p / 2) % 6) + p % 2,
                  first: (p % 2 == 0), last: (p % 2 == 1), cyc: 0};

    // start  stall  busy valid row col  A  B  done
    vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 0, 0, 1'b0};  // stall in IDLE: no effect
    vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, -1, -1, 0, 0, 1'b0};  // start with stall: run begins
    vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, -1, -1, 0, 0, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, -1, -1, 0, 0, 1'b0};  // issue (0,0)
    vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b1,  0,  0, 0, 1, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 1'b1,  0,  1, 0, 1, 1'b0};  // stall: counters hold
    vt[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, -1, -1, 0, 2, 1'b0};  // start while busy ignored
    vt[7]  = '{1'b0, 1'b0, 1'b1, 1'b1,  0,  2, 0, 3, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b1,  0,  3, 0, 4, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b1,  0,  4, 0, 5, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b1, 1'b1,  0,  5, 1, 0, 1'b0};  // j wraps, i increments
    vt[11] = '{1'b0, 1'b0, 1'b1, 1'b1,  1,  0, 1, 1, 1'b0};

    repeat (2) step();
    check("rst_busy", b4.busy, 0);
    check("rst_done", b4.done, 0);
    check("rst_valid", b4.data_valid, 0);
    check("rst_cntA", b4.counter_A, 0);
    check("rst_cntB", b4.counter_B, 0);
    check("rst_row", b4.out_row, 0);
    check("rst_col", b4.out_col, 0);
    check("rst_kfirst", b4.k_first, 0);
    check("rst_klast", b4.k_last, 0);
    check("rst_nk2_busy", b8.busy, 0);
    check("rst_nk2_valid", b8.data_valid, 0);
    rst = 1'b0;
    step();

    // Run 1: cycle table, then the rest of the product without stall.
    clear_mon(0);
    for (int r = 0; r < 12; r++) begin
      b4.start = vt[r].start;
      b4.stall = vt[r].stall;
      step();
      check($sformatf("vec%0d_busy", r), b4.busy, vt[r].busy);
      check($sformatf("vec%0d_valid", r), b4.data_valid, vt[r].valid);
      check($sformatf("vec%0d_cntA", r), b4.counter_A, vt[r].ca);
      check($sformatf("vec%0d_cntB", r), b4.counter_B, vt[r].cb);
      check($sformatf("vec%0d_done", r), b4.done, vt[r].done);
      if (vt[r].valid) begin
        check($sformatf("vec%0d_row", r), b4.out_row, vt[r].row);
        check($sformatf("vec%0d_col", r), b4.out_col, vt[r].col);
      end
    end
    b4.start = 1'b0; b4.stall = 1'b0;
    wait_done(0, 200, "run1");
    compare_run(0, "run1");
    check("run1_busy_after", b4.busy, 0);

    // Run 2: stall three cycles after the 10th issue.
    clear_mon(0);
    b4.start = 1'b1; step(); b4.start = 1'b0;
    repeat (10) step();
    b4.stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      check($sformatf("stall%0d_cntA", s), b4.counter_A, 1);
      check($sformatf("stall%0d_cntB", s), b4.counter_B, 3);
    end
    b4.stall = 1'b0;
    wait_done(0, 200, "run2");
    compare_run(0, "run2");
    if (q4.size() > 10) check("run2_gap_at_10", q4[10].cyc - q4[9].cyc, 4);
    else check("run2_gap_at_10", q4.size(), 11);
    odd_gaps = 0;
    for (int p = 1; p < q4.size(); p++) if (q4[p].cyc - q4[p-1].cyc != 1) odd_gaps++;
    check("run2_gap_count", odd_gaps, 1);

    // Run 3: reset at pair 20, then a fresh full run.
    clear_mon(0);
    b4.start = 1'b1; step(); b4.start = 1'b0;
    n = 0;
    while (q4.size() < 20 && n < 100) begin step(); n++; end
    check("run3_reached_pair20", q4.size() >= 20, 1);
    #2 rst = 1'b1;
    #1;
    check("run3_rst_busy", b4.busy, 0);
    check("run3_rst_valid", b4.data_valid, 0);
    check("run3_rst_cntA", b4.counter_A, 0);
    check("run3_rst_cntB", b4.counter_B, 0);
    check("run3_rst_row", b4.out_row, 0);
    check("run3_rst_col", b4.out_col, 0);
    step(); step();
    rst = 1'b0;
    repeat (6) step();
    check("run3_no_done", done_cnt4, 0);
    check("run3_idle_busy", b4.busy, 0);
    clear_mon(0);
    b4.start = 1'b1; step(); b4.start = 1'b0;
    wait_done(0, 200, "run3b");
    compare_run(0, "run3b");

    // Run 4: NK=2 instance.
    clear_mon(1);
    b8.start = 1'b1; step(); b8.start = 1'b0;
    wait_done(1, 300, "nk2");
    compare_run(1, "nk2");

`ifdef MATMUL_ADDR_SEQ_STALL_CNT_EN
    b4.stall = 1'b1; repeat (4) step();
    b4.stall = 1'b0; b4.start = 1'b1; step();
    b4.start = 1'b0; b4.stall = 1'b1; repeat (5) step();
    b4.stall = 1'b0;
    clear_mon(0);
    wait_done(0, 200, "scnt");
    check("stall_cycles", sc4, 5);
    check("stall_cycles_nk2", sc8, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
